// File: rtl/watch_pkg.sv
// Shared widths, limits and time record for the watch counter, FND controller and button FSM.
package watch_pkg;

  localparam int unsigned CS_W   = 7;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  localparam logic [CS_W-1:0]   CS_MAX   = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [HOUR_W-1:0] h;
    logic [MIN_W-1:0]  m;
    logic [SEC_W-1:0]  s;
    logic [CS_W-1:0]   cs;
  } watch_time_t;

  function automatic logic [SEC_W-1:0] inc_sec_wrap(input logic [SEC_W-1:0] v);
    return (v == SEC_MAX) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [MIN_W-1:0] inc_min_wrap(input logic [MIN_W-1:0] v);
    return (v == MIN_MAX) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [HOUR_W-1:0] inc_hour_wrap(input logic [HOUR_W-1:0] v);
    return (v == HOUR_MAX) ? '0 : v + 1'b1;
  endfunction

  // Full centisecond advance with carry through every field.
  function automatic watch_time_t cascade(input watch_time_t t);
    watch_time_t n;
    n = t;
    if (t.cs == CS_MAX) begin
      n.cs = '0;
      if (t.s == SEC_MAX) begin
        n.s = '0;
        if (t.m == MIN_MAX) begin
          n.m = '0;
          n.h = inc_hour_wrap(t.h);
        end else begin
          n.m = t.m + 1'b1;
        end
      end else begin
        n.s = t.s + 1'b1;
      end
    end else begin
      n.cs = t.cs + 1'b1;
    end
    return n;
  endfunction

  function automatic logic is_day_end(input watch_time_t t);
    return (t.cs == CS_MAX) && (t.s == SEC_MAX) && (t.m == MIN_MAX) && (t.h == HOUR_MAX);
  endfunction

endpackage

// File: rtl/watch_tick_gen.sv
// Centisecond prescaler: counts 0..DIV-1 while enabled, holds while disabled.
// tick is the combinational advance strobe for the edge that wraps the prescaler.
module watch_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/watch_time_counter.sv
// Watch time base: 100 Hz tick cascaded through cs/s/m/h, with run/stop, clear and
// per-field increment for setting the clock while stopped.
module watch_time_counter
  import watch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              clear,
  input  logic              inc_sec,
  input  logic              inc_min,
  input  logic              inc_hour,
  output logic [CS_W-1:0]   ms_counter,
  output logic [SEC_W-1:0]  s_counter,
  output logic [MIN_W-1:0]  m_counter,
  output logic [HOUR_W-1:0] h_counter,
  output logic              tick,
  output logic              day_wrap
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;

  logic        step;
  logic        tick_q;
  logic        day_wrap_q;
  watch_time_t time_q;
  watch_time_t time_d;

  watch_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (clear),
    .tick (step)
  );

  // step already excludes clear and requires run, so inc and cascade never collide.
  always_comb begin
    time_d = time_q;
    if (step) begin
      time_d = cascade(time_q);
    end else if (!run && !clear) begin
      if (inc_sec)  time_d.s = inc_sec_wrap(time_q.s);
      if (inc_min)  time_d.m = inc_min_wrap(time_q.m);
      if (inc_hour) time_d.h = inc_hour_wrap(time_q.h);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q     <= '0;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
    end else if (clear) begin
      time_q     <= '0;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      tick_q     <= step;
      day_wrap_q <= step && is_day_end(time_q);
    end
  end

  assign ms_counter = time_q.cs;
  assign s_counter  = time_q.s;
  assign m_counter  = time_q.m;
  assign h_counter  = time_q.h;
  assign tick       = tick_q;
  assign day_wrap   = day_wrap_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench for watch_time_counter with DIV=10 (CLK_HZ=1000, TICK_HZ=100).
module tb_watch_time_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       clear = 1'b0;
  logic       inc_sec = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic [6:0] ms_counter;
  logic [5:0] s_counter;
  logic [5:0] m_counter;
  logic [4:0] h_counter;
  logic       tick;
  logic       day_wrap;
  logic [23:0] now_t;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign now_t = {h_counter, m_counter, s_counter, ms_counter};

  watch_time_counter #(
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .clear      (clear),
    .inc_sec    (inc_sec),
    .inc_min    (inc_min),
    .inc_hour   (inc_hour),
    .ms_counter (ms_counter),
    .s_counter  (s_counter),
    .m_counter  (m_counter),
    .h_counter  (h_counter),
    .tick       (tick),
    .day_wrap   (day_wrap)
  );

  function automatic logic [23:0] hms(input int h, input int m, input int s, input int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel = {hour, min, sec}; held high for n edges.
  task automatic pulse(input logic [2:0] sel, input int n);
    {inc_hour, inc_min, inc_sec} = sel;
    repeat (n) step();
    {inc_hour, inc_min, inc_sec} = 3'b000;
  endtask

  task automatic tick_at(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      step();
      check(tag, 32'(tick), 32'(i == n));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int seen;
    #2;
    check("reset_time", 32'(now_t), 32'(hms(0, 0, 0, 0)));
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_dw", 32'(day_wrap), 32'd0);
    run = 1'b1;
    #10 rst = 1'b0;

    // First tick after exactly DIV clocks, then every DIV.
    tick_at(10, "tick1");
    check("ms1", 32'(ms_counter), 32'd1);
    tick_at(10, "tick2");
    check("ms2", 32'(ms_counter), 32'd2);
    step();
    check("tick_one_cycle", 32'(tick), 32'd0);
    run = 1'b0;
    do_clear();
    check("clear_stopped", 32'(now_t), 32'(hms(0, 0, 0, 0)));

    // 00:59:59.99 -> 01:00:00.00 in one edge.
    pulse(3'b001, 59);
    pulse(3'b010, 59);
    check("set_0059", 32'(now_t), 32'(hms(0, 59, 59, 0)));
    run = 1'b1;
    repeat (990) step();
    check("at_0059_99", 32'(now_t), 32'(hms(0, 59, 59, 99)));
    check("at_0059_99_tick", 32'(tick), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i < 10) check("hold_0059", 32'(now_t), 32'(hms(0, 59, 59, 99)));
    end
    check("roll_hour", 32'(now_t), 32'(hms(1, 0, 0, 0)));
    check("roll_hour_tick", 32'(tick), 32'd1);
    check("roll_hour_dw", 32'(day_wrap), 32'd0);
    run = 1'b0;

    // 23:59:59.99 -> 00:00:00.00 with day_wrap.
    pulse(3'b100, 22);
    pulse(3'b010, 59);
    pulse(3'b001, 59);
    check("set_2359", 32'(now_t), 32'(hms(23, 59, 59, 0)));
    run = 1'b1;
    repeat (990) step();
    check("at_2359_99", 32'(now_t), 32'(hms(23, 59, 59, 99)));
    tick_at(10, "day_tick");
    check("day_roll", 32'(now_t), 32'(hms(0, 0, 0, 0)));
    check("day_wrap_hi", 32'(day_wrap), 32'd1);
    step();
    check("day_wrap_lo", 32'(day_wrap), 32'd0);
    run = 1'b0;
    do_clear();

    // Field increments wrap without carry.
    pulse(3'b010, 5);
    pulse(3'b100, 3);
    pulse(3'b001, 59);
    check("sec59", 32'(now_t), 32'(hms(3, 5, 59, 0)));
    pulse(3'b001, 1);
    check("sec_wrap", 32'(now_t), 32'(hms(3, 5, 0, 0)));
    pulse(3'b100, 24);
    check("hour24", 32'(now_t), 32'(hms(3, 5, 0, 0)));
    pulse(3'b111, 1);
    check("inc_all", 32'(now_t), 32'(hms(4, 6, 1, 0)));
    check("inc_no_tick", 32'(tick), 32'd0);
    run = 1'b1;
    pulse(3'b010, 1);
    run = 1'b0;
    check("inc_while_run", 32'(now_t), 32'(hms(4, 6, 1, 0)));

    // Prescaler holds across stop.
    do_clear();
    run = 1'b1;
    repeat (6) step();
    run = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tick) seen++;
    end
    check("stopped_ticks", 32'(seen), 32'd0);
    check("stopped_ms", 32'(ms_counter), 32'd0);
    run = 1'b1;
    tick_at(4, "resume_tick");
    check("resume_ms", 32'(ms_counter), 32'd1);

    // Clear while running at 12:34:56.78.
    run = 1'b0;
    do_clear();
    pulse(3'b100, 12);
    pulse(3'b010, 34);
    pulse(3'b001, 56);
    run = 1'b1;
    repeat (780) step();
    check("at_1234", 32'(now_t), 32'(hms(12, 34, 56, 78)));
    do_clear();
    check("clear_run", 32'(now_t), 32'(hms(0, 0, 0, 0)));
    check("clear_run_tick", 32'(tick), 32'd0);
    tick_at(10, "post_clear_tick");
    check("post_clear_ms", 32'(ms_counter), 32'd1);

    // Asynchronous reset mid-cycle.
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_time", 32'(now_t), 32'(hms(0, 0, 0, 0)));
    check("async_rst_tick", 32'(tick), 32'd0);
    #10 rst = 1'b0;
    tick_at(10, "post_rst_tick");
    check("post_rst_ms", 32'(ms_counter), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
